// File: rtl/jtframe_sdram64_bist.sv
// jtframe_sdram64_bist: LFSR traffic generator and read checker for one jtframe_sdram64 bank port
// Ports: ba_* drive one bank of jtframe_sdram64 (addr/rd/wr/dout/mask out, ack/dok/rdy/dout in).
// busy/fill_done/err/err_cnt/err_addr/proto_err/timeout report status; lat_* hold latency statistics.
module jtframe_sdram64_bist #(
  parameter int          DW        = 64,
  parameter int          RW        = 0,
  parameter int          FILL      = 1,
  parameter int          MAXA      = 21,
  parameter int          IDLE      = 32,
  parameter int          WRCHANCE  = 13,
  parameter logic [31:0] SEED      = 32'h1234_5678,
  parameter int          STALL_MAX = 4000
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        start,
  output logic [21:0] ba_addr,
  output logic        ba_rd,
  output logic        ba_wr,
  output logic [15:0] ba_dout,
  output logic [1:0]  ba_dout_m,
  input  logic        ba_ack,
  input  logic        ba_dok,
  input  logic        ba_rdy,
  input  logic [15:0] dout,
  output logic        busy,
  output logic        fill_done,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [21:0] err_addr,
  output logic        proto_err,
  output logic        timeout,
  output logic [15:0] lat_best,
  output logic [15:0] lat_worst,
  output logic [47:0] lat_sum,
  output logic [31:0] lat_cnt
);
  localparam int          NW    = DW / 16;
  localparam int          LB    = $clog2(NW);
  localparam logic [21:0] ALAST = 22'((64'd1 << (MAXA + 1)) - 64'd1);
  localparam logic [21:0] AMSK  = ALAST & ~22'((1 << LB) - 1);
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_FILL_REQ, S_FILL_WAIT, S_RUN_DEC, S_RUN_WAIT, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_lfsr, r_stall, r_lcnt;
  logic [21:0] r_addr, r_eaddr;
  logic        r_rd, r_wr, r_isrd, r_fill, r_err, r_proto, r_to;
  logic [15:0] r_dout, r_ecnt, r_lbest, r_lworst, r_lat;
  logic [1:0]  r_dm;
  logic [47:0] r_lsum;
  logic [31:0] w_lfsr_nx;
  logic [21:0] w_ra;
  logic [1:0]  w_m;
  logic [15:0] w_wd;
  logic        w_go, w_wr;
  logic [DW-1:0] w_burst, w_exp;

  function automatic logic [15:0] pat(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], 10'd0} ^ SEED[15:0];
  endfunction

  assign w_lfsr_nx = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'd0);
  assign w_go      = {1'b0, r_lfsr[7:0]} >= 9'(IDLE);
  assign w_wr      = (RW != 0) && ({1'b0, r_lfsr[15:8]} < 9'(WRCHANCE));
  assign w_ra      = r_lfsr[31:10] & AMSK;
  assign w_m       = r_lfsr[17:16];
  // masked lanes carry inverted pattern so a lane the controller wrongly writes is caught later
  assign w_wd      = pat(w_ra) ^ {{8{w_m[1]}}, {8{w_m[0]}}};

  always_comb begin
    w_exp = '0;
    for (int i = 0; i < NW; i++) w_exp[16*i +: 16] = pat(r_addr + 22'(i));
  end

  // burst assembly: each dok shifts into the top, so the first word ends up lowest
  generate
    if (DW == 16) begin : g_one
      assign w_burst = dout;
    end else begin : g_sh
      logic [DW-17:0] r_sh;
      always_ff @(posedge clk, posedge rst) begin
        if (rst) r_sh <= '0;
        else if (ba_dok) r_sh <= w_burst[DW-1:16];
      end
      assign w_burst = {dout, r_sh};
    end
  endgenerate

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_isrd   <= 1'b0;
      r_dout   <= '0;
      r_dm     <= '0;
      r_fill   <= FILL == 0;
      r_err    <= 1'b0;
      r_ecnt   <= '0;
      r_eaddr  <= '0;
      r_proto  <= 1'b0;
      r_to     <= 1'b0;
      r_lbest  <= 16'hFFFF;
      r_lworst <= '0;
      r_lsum   <= '0;
      r_lcnt   <= '0;
      r_lat    <= '0;
      r_stall  <= '0;
    end else begin
      if (r_state == S_RUN_DEC) r_lfsr <= w_lfsr_nx;
      case (r_state)
        S_IDLE: if (start) r_state <= (FILL != 0 && !r_fill) ? S_FILL_REQ : S_RUN_DEC;
        S_FILL_REQ: begin
          r_wr    <= 1'b1;
          r_isrd  <= 1'b0;
          r_dout  <= pat(r_addr);
          r_dm    <= 2'b00;
          r_stall <= '0;
          r_state <= S_FILL_WAIT;
        end
        S_RUN_DEC: begin
          if (!start) r_state <= S_IDLE;
          else if (w_go) begin
            r_addr  <= w_ra;
            r_rd    <= !w_wr;
            r_wr    <= w_wr;
            r_isrd  <= !w_wr;
            r_dout  <= w_wd;
            r_dm    <= w_m;
            r_lat   <= 16'd1;
            r_stall <= '0;
            r_state <= S_RUN_WAIT;
          end
        end
        S_FILL_WAIT, S_RUN_WAIT: begin
          if (ba_ack || ba_rdy) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
          end
          // rdy without the request ever being acked; an ack in the same cycle is legal
          if (ba_rdy && (r_rd || r_wr) && !ba_ack) r_proto <= 1'b1;
          if (!ba_rdy) r_lat <= r_lat + 16'd1;
          if (ba_rdy && r_state == S_FILL_WAIT) begin
            r_addr  <= r_addr == ALAST ? 22'd0 : r_addr + 22'd1;
            r_fill  <= r_fill || r_addr == ALAST;
            r_state <= r_addr == ALAST ? S_RUN_DEC : S_FILL_REQ;
          end else if (ba_rdy) begin
            r_lbest  <= r_lat < r_lbest ? r_lat : r_lbest;
            r_lworst <= r_lat > r_lworst ? r_lat : r_lworst;
            r_lsum   <= r_lsum + 48'(r_lat);
            r_lcnt   <= r_lcnt + 32'd1;
            if (r_isrd && w_burst != w_exp) begin
              r_err  <= 1'b1;
              r_ecnt <= r_ecnt + 16'(r_ecnt != 16'hFFFF);
              if (!r_err) r_eaddr <= r_addr;
            end
            r_state <= start ? S_RUN_DEC : S_IDLE;
          end else if (r_stall == 32'(STALL_MAX - 1)) begin
            r_stall <= r_stall + 32'd1;
            r_to    <= 1'b1;
            r_state <= S_HALT;
          end else r_stall <= r_stall + 32'd1;
        end
        S_HALT: begin
          r_rd <= 1'b0;
          r_wr <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ba_addr   = r_addr;
  assign ba_rd     = r_rd;
  assign ba_wr     = r_wr;
  assign ba_dout   = r_dout;
  assign ba_dout_m = r_dm;
  assign busy      = r_state != S_IDLE;
  assign fill_done = r_fill;
  assign err       = r_err;
  assign err_cnt   = r_ecnt;
  assign err_addr  = r_eaddr;
  assign proto_err = r_proto;
  assign timeout   = r_to;
  assign lat_best  = r_lbest;
  assign lat_worst = r_lworst;
  assign lat_sum   = r_lsum;
  assign lat_cnt   = r_lcnt;
endmodule

// File: tb/tb_jtframe_sdram64_bist.sv
// tb_jtframe_sdram64_bist: scoreboard bench for fill, random reads/writes, error capture, protocol and timeout
module tb_jtframe_sdram64_bist;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  typedef struct {logic wr; logic [21:0] a; logic [15:0] d; logic [1:0] m;} exp_t;
  exp_t qa[$], qb[$];
  int n_pass = 0, n_tot = 0, n_req_a = 0, n_req_b = 0, rd_idx = 0;
  logic hang = 1'b0, early = 1'b0, a_prev = 1'b0, b_prev = 1'b0;
  logic [21:0] bad_addr;

  logic a_start, a_rd, a_wr, a_ack, a_dok, a_rdy, a_busy, a_fill, a_err, a_proto, a_to;
  logic [21:0] a_addr, a_eaddr;
  logic [15:0] a_dout, a_din, a_ecnt, a_lbest, a_lworst;
  logic [1:0]  a_dm;
  logic [47:0] a_lsum;
  logic [31:0] a_lcnt;
  logic b_start, b_rd, b_wr, b_ack, b_rdy, b_busy, b_fill, b_err, b_proto, b_to;
  logic [21:0] b_addr, b_eaddr;
  logic [15:0] b_dout, b_ecnt, b_lbest, b_lworst;
  logic [1:0]  b_dm;
  logic [47:0] b_lsum;
  logic [31:0] b_lcnt;

  jtframe_sdram64_bist #(.DW(64), .RW(0), .FILL(1), .MAXA(3), .STALL_MAX(20)) u_a (
    .rst(rst), .clk(clk), .start(a_start), .ba_addr(a_addr), .ba_rd(a_rd), .ba_wr(a_wr),
    .ba_dout(a_dout), .ba_dout_m(a_dm), .ba_ack(a_ack), .ba_dok(a_dok), .ba_rdy(a_rdy),
    .dout(a_din), .busy(a_busy), .fill_done(a_fill), .err(a_err), .err_cnt(a_ecnt),
    .err_addr(a_eaddr), .proto_err(a_proto), .timeout(a_to), .lat_best(a_lbest),
    .lat_worst(a_lworst), .lat_sum(a_lsum), .lat_cnt(a_lcnt));

  jtframe_sdram64_bist #(.DW(64), .RW(1), .FILL(0), .MAXA(3), .WRCHANCE(256)) u_b (
    .rst(rst), .clk(clk), .start(b_start), .ba_addr(b_addr), .ba_rd(b_rd), .ba_wr(b_wr),
    .ba_dout(b_dout), .ba_dout_m(b_dm), .ba_ack(b_ack), .ba_dok(1'b0), .ba_rdy(b_rdy),
    .dout(16'h0000), .busy(b_busy), .fill_done(b_fill), .err(b_err), .err_cnt(b_ecnt),
    .err_addr(b_eaddr), .proto_err(b_proto), .timeout(b_to), .lat_best(b_lbest),
    .lat_worst(b_lworst), .lat_sum(b_lsum), .lat_cnt(b_lcnt));

  function automatic logic [15:0] pat(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], 10'd0} ^ 16'h5678;
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] l);
    return l[0] ? ({1'b0, l[31:1]} ^ 32'h8020_0003) : {1'b0, l[31:1]};
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // responder A: ack one cycle after the request, then four doks with rdy on the last
  initial begin
    logic [21:0] ra;
    logic isrd;
    a_ack = 0; a_dok = 0; a_rdy = 0; a_din = 0;
    forever begin
      @(negedge clk);
      a_ack = 0; a_dok = 0; a_rdy = 0; a_din = 0;
      if ((a_rd | a_wr) && !hang) begin
        ra = a_addr;
        isrd = a_rd;
        if (early) a_rdy = 1;
        else begin
          @(negedge clk);
          a_ack = 1;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_ack = 0; a_dok = 1; a_rdy = (i == 3);
            a_din = pat(ra + 22'(i)) ^ ((isrd && (rd_idx == 2 || rd_idx == 4) && i == 2) ? 16'h0100 : 16'h0000);
          end
          if (isrd) rd_idx++;
        end
      end
    end
  end

  // responder B: ack and rdy together one cycle after the request
  initial begin
    b_ack = 0; b_rdy = 0;
    forever begin
      @(negedge clk);
      b_ack = 0; b_rdy = 0;
      if (b_rd | b_wr) begin
        @(negedge clk);
        b_ack = 1; b_rdy = 1;
      end
    end
  end

  // monitors: every new request is popped against the predicted one
  always @(negedge clk) begin
    exp_t e;
    if ((a_rd | a_wr) && !a_prev) begin
      n_req_a++;
      if (qa.size() == 0) chk("a_unexpected_req", {a_wr, a_addr}, 23'h7fffff);
      else begin
        e = qa.pop_front();
        chk("a_req", {a_wr, a_addr, a_wr ? a_dout : 16'h0, a_wr ? a_dm : 2'b0}, {e.wr, e.a, e.d, e.m});
      end
    end
    a_prev = a_rd | a_wr;
    if ((b_rd | b_wr) && !b_prev) begin
      n_req_b++;
      if (qb.size() == 0) chk("b_unexpected_req", {b_wr, b_addr}, 23'h7fffff);
      else begin
        e = qb.pop_front();
        chk("b_req", {b_wr, b_addr, b_wr ? b_dout : 16'h0, b_wr ? b_dm : 2'b0}, {e.wr, e.a, e.d, e.m});
      end
    end
    b_prev = b_rd | b_wr;
  end

  initial begin
    exp_t e;
    logic [31:0] l;
    int t, n, rq;
    rst = 1; a_start = 0; b_start = 0;
    for (int k = 0; k < 16; k++) begin
      e.wr = 1; e.a = 22'(k); e.d = pat(22'(k)); e.m = 0;
      qa.push_back(e);
    end
    l = 32'h1234_5678;
    for (int k = 0; k < 60; k++) begin
      while (l[7:0] < 8'd32) l = lstep(l);
      e.wr = 0; e.a = l[31:10] & 22'h00000C; e.d = 0; e.m = 0;
      if (k == 2) bad_addr = e.a;
      qa.push_back(e);
      l = lstep(l);
    end
    l = 32'h1234_5678;
    for (int k = 0; k < 12; k++) begin
      while (l[7:0] < 8'd32) l = lstep(l);
      e.wr = 1; e.a = l[31:10] & 22'h00000C; e.m = l[17:16];
      e.d = pat(e.a) ^ {{8{e.m[1]}}, {8{e.m[0]}}};
      qb.push_back(e);
      l = lstep(l);
    end
    repeat (3) tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_fill_done", a_fill, 0);
    chk("rst_lat_best", a_lbest, 16'hFFFF);
    chk("rst_lat_cnt", a_lcnt, 0);
    chk("rst_req", {a_rd, a_wr}, 0);
    chk("rst_err", {a_err, a_ecnt, a_proto, a_to}, 0);
    chk("rst_b_fill_done", b_fill, 1);
    rst = 0;
    // instance B: every access is a masked single-word write
    b_start = 1;
    for (t = 0; t < 3000 && b_lcnt < 6; t++) tick();
    for (t = 0; t < 100 && !b_wr; t++) tick();
    b_start = 0;
    for (t = 0; t < 50 && b_busy; t++) tick();
    chk("b_busy", b_busy, 0);
    chk("b_lat_cnt", b_lcnt, 7);
    chk("b_lat_sum", b_lsum, 14);
    chk("b_lat_best_worst", {b_lbest, b_lworst}, {16'd2, 16'd2});
    chk("b_err_proto", {b_err, b_proto, b_to}, 0);
    chk("b_req_cnt", n_req_b, 7);
    // instance A: fill then random reads
    a_start = 1;
    for (t = 0; t < 1000 && !a_fill; t++) tick();
    chk("fill_done", a_fill, 1);
    chk("fill_writes", n_req_a, 16);
    chk("fill_no_lat", a_lcnt, 0);
    for (t = 0; t < 500 && a_lcnt < 1; t++) tick();
    chk("rd1_lat_cnt", a_lcnt, 1);
    chk("rd1_lat_best_worst", {a_lbest, a_lworst}, {16'd6, 16'd6});
    chk("rd1_lat_sum", a_lsum, 6);
    chk("rd1_err", a_err, 0);
    for (t = 0; t < 1000 && a_lcnt < 5; t++) tick();
    chk("rd5_lat_cnt", a_lcnt, 5);
    chk("rd5_err", a_err, 1);
    chk("rd5_err_cnt", a_ecnt, 2);
    chk("rd5_err_addr", a_eaddr, bad_addr);
    chk("rd5_lat_sum", a_lsum, 30);
    // drop start while a read is outstanding
    for (t = 0; t < 500 && !a_rd; t++) tick();
    a_start = 0;
    for (t = 0; t < 20 && !a_rdy; t++) tick();
    chk("stop_busy_at_rdy", {a_rdy, a_busy}, 2'b11);
    tick();
    chk("stop_busy_after", a_busy, 0);
    // rdy before ack
    early = 1;
    a_start = 1;
    for (t = 0; t < 500 && !a_proto; t++) tick();
    chk("proto_err", a_proto, 1);
    chk("proto_lat_best", a_lbest, 1);
    for (t = 0; t < 500 && !a_rd; t++) tick();
    a_start = 0;
    for (t = 0; t < 20 && a_busy; t++) tick();
    chk("proto_stop", a_busy, 0);
    early = 0;
    // no ack ever: timeout
    hang = 1;
    a_start = 1;
    for (t = 0; t < 500 && !a_rd; t++) tick();
    n = 0;
    while (n < 100 && !a_to) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 20);
    chk("timeout_req_held", a_rd, 1);
    tick();
    chk("timeout_req_drop", a_rd, 0);
    rq = n_req_a;
    repeat (4) begin
      a_start = 0;
      repeat (3) tick();
      a_start = 1;
      repeat (3) tick();
    end
    chk("halt_no_req", n_req_a, rq);
    chk("halt_state", {a_busy, a_to, a_rd}, 3'b110);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
